mips_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit with HI/LO registers for the MIPS core: executes MULT, MULTU, DIV and DIVU over WIDTH+1 clock cycles and provides MTHI/MTLO write access. It sits beside the ALU (`ula`) and is driven by the control path through a Start/Busy/Done handshake. The control path stalls instruction fetch while Busy is high. Hi and Lo feed the register-file write-data mux for MFHI/MFLO.

---
 rtl/mips_muldiv.sv | 153 +++++++++++++++
 tb/tb_mips_muldiv.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_muldiv : iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mips_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int c_CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   r_count;
  logic                 r_is_div;
  logic                 r_neg_a;
  logic                 r_neg_b;
  logic [WIDTH-1:0]     r_opnd;   // multiplicand for MULT*, divisor for DIV*
  logic [2*WIDTH-1:0]   r_acc;    // product accumulator / dividend-quotient shifter
  logic [WIDTH-1:0]     r_rem;
  logic                 r_done;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_signed;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_trial;
  logic [WIDTH:0]       w_diff;
  logic                 w_neg_res;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_remf;

  assign w_signed = ~Op[0];
  assign w_mag_a  = (w_signed && A[WIDTH-1]) ? -A : A;
  assign w_mag_b  = (w_signed && B[WIDTH-1]) ? -B : B;

  // Shift-add step: add multiplicand to the upper half when the current multiplier bit is set
  assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  // Restoring step: a non-negative difference means the quotient bit is 1
  assign w_trial = {r_rem, r_acc[WIDTH-1]};
  assign w_diff  = w_trial - {1'b0, r_opnd};

  assign w_neg_res = r_neg_a ^ r_neg_b;
  assign w_prod    = w_neg_res ? -r_acc : r_acc;
  assign w_quot    = w_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_remf    = r_neg_a ? -r_rem : r_rem;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_state_nxt = S_CALC;
      S_CALC:  if (r_count == c_CNT_W'(1)) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count  <= '0;
      r_is_div <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (HiWrite) r_hi <= WData;
          if (LoWrite) r_lo <= WData;
          if (Start) begin
            r_is_div <= Op[1];
            r_neg_a  <= w_signed & A[WIDTH-1];
            r_neg_b  <= w_signed & B[WIDTH-1];
            r_count  <= c_CNT_W'(WIDTH);
            r_rem    <= '0;
            if (Op[1]) begin
              r_opnd <= w_mag_b;
              r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
            end else begin
              r_opnd <= w_mag_a;
              r_acc  <= {{WIDTH{1'b0}}, w_mag_b};
            end
          end
        end
        S_CALC: begin
          r_count <= r_count - c_CNT_W'(1);
          if (r_is_div) begin
            r_rem                <= w_diff[WIDTH] ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_acc[WIDTH-1:0]     <= {r_acc[WIDTH-2:0], ~w_diff[WIDTH]};
          end else begin
            r_acc <= {w_sum, r_acc[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          if (r_is_div) begin
            // Divide by zero: remainder already equals |A|, sign fix restores A
            r_lo <= (r_opnd == '0) ? {WIDTH{1'b1}} : w_quot;
            r_hi <= w_remf;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy = (r_state == S_CALC) || (r_state == S_FIX);
  assign Done = r_done;
  assign Hi   = r_hi;
  assign Lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mips_muldiv.sv
`timescale 1ns/1ps
// Self-checking bench for mips_muldiv: directed cases plus random ops against an arithmetic model.
module tb_mips_muldiv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s32, hw32, lw32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, wd32;
  logic        busy32, done32;
  logic [31:0] hi32, lo32;

  logic        s8, hw8, lw8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wd8;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  mips_muldiv #(.WIDTH(32)) u_dut32 (
    .CLK(clk), .RST(rst), .Start(s32), .Op(op32), .A(a32), .B(b32),
    .HiWrite(hw32), .LoWrite(lw32), .WData(wd32),
    .Busy(busy32), .Done(done32), .Hi(hi32), .Lo(lo32)
  );

  mips_muldiv #(.WIDTH(8)) u_dut8 (
    .CLK(clk), .RST(rst), .Start(s8), .Op(op8), .A(a8), .B(b8),
    .HiWrite(hw8), .LoWrite(lw8), .WData(wd8),
    .Busy(busy8), .Done(done8), .Hi(hi8), .Lo(lo8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain-arithmetic reference: signed/unsigned products, truncating division, MIPS div-by-zero rule
  function automatic void ref_model(input int w, input logic [1:0] op,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo);
    longint unsigned mask = (64'd1 << w) - 64'd1;
    longint unsigned ua   = {32'd0, a} & mask;
    longint unsigned ub   = {32'd0, b} & mask;
    longint          sa   = a[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    longint          sb   = b[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    longint          sp;
    longint unsigned up;
    case (op)
      2'b00: begin
        sp = sa * sb;
        hi = 32'((longint'(sp >>> w)) & longint'(mask));
        lo = 32'(sp & longint'(mask));
      end
      2'b01: begin
        up = ua * ub;
        hi = 32'((up >> w) & mask);
        lo = 32'(up & mask);
      end
      2'b10: begin
        if (ub == 0) begin
          hi = 32'(ua); lo = 32'(mask);
        end else begin
          hi = 32'((sa % sb) & longint'(mask));
          lo = 32'((sa / sb) & longint'(mask));
        end
      end
      default: begin
        if (ub == 0) begin
          hi = 32'(ua); lo = 32'(mask);
        end else begin
          hi = 32'(ua % ub);
          lo = 32'(ua / ub);
        end
      end
    endcase
  endfunction

  task automatic issue(input bit w8, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      s8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      s32 = 1'b1; op32 = op; a32 = a; b32 = b;
    end
    @(posedge clk); #1;
    s8 = 1'b0; s32 = 1'b0;
    a32 = $urandom; b32 = $urandom; op32 = 2'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom); op8 = 2'($urandom);
  endtask

  // Counts edges from the Start edge until Done is seen; lat = -1 on timeout
  task automatic wait_done(input bit w8, input bit disturb, output int lat, output int busy_cyc);
    bit found = 1'b0;
    lat = 0; busy_cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (disturb) begin
        if (lat == 5) begin s32 = 1'b1; a32 = 32'd99; b32 = 32'd77; op32 = 2'b11; end
        else if (lat == 6) s32 = 1'b0;
        if (lat == 10) begin hw32 = 1'b1; wd32 = 32'hDEADBEEF; end
        else if (lat == 11) hw32 = 1'b0;
      end
      if ((w8 ? busy8 : busy32) === 1'b1) busy_cyc++;
      if ((w8 ? done8 : done32) === 1'b1) begin found = 1'b1; break; end
      lat++;
    end
    if (!found) lat = -1;
  endtask

  task automatic run_check(input bit w8, input string tag, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    int lat, bc;
    ref_model(w8 ? 8 : 32, op, a, b, eh, el);
    issue(w8, op, a, b);
    wait_done(w8, 1'b0, lat, bc);
    check({tag, "_hi"}, w8 ? {56'd0, hi8} : {32'd0, hi32}, {32'd0, eh});
    check({tag, "_lo"}, w8 ? {56'd0, lo8} : {32'd0, lo32}, {32'd0, el});
    check({tag, "_lat"}, 64'(lat), w8 ? 64'd9 : 64'd33);
  endtask

  initial begin : main
    int lat, bc, dcount;
    logic [31:0] eh, el;
    rst = 1'b1;
    s32 = 0; hw32 = 0; lw32 = 0; op32 = 0; a32 = 0; b32 = 0; wd32 = 0;
    s8 = 0; hw8 = 0; lw8 = 0; op8 = 0; a8 = 0; b8 = 0; wd8 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {63'd0, busy32}, 64'd0);
    check("rst_done", {63'd0, done32}, 64'd0);
    check("rst_hi", {32'd0, hi32}, 64'd0);
    check("rst_lo", {32'd0, lo32}, 64'd0);
    check("rst_busy8", {63'd0, busy8}, 64'd0);

    // MULTU all-ones squared, latency and busy length
    issue(1'b0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(1'b0, 1'b0, lat, bc);
    check("multu_hi", {32'd0, hi32}, 64'hFFFFFFFE);
    check("multu_lo", {32'd0, lo32}, 64'h00000001);
    check("multu_lat", 64'(lat), 64'd33);
    check("multu_busy", 64'(bc), 64'd33);
    @(negedge clk);
    check("done_pulse", {63'd0, done32}, 64'd0);

    // MULT then DIV issued back-to-back in the Done cycle
    issue(1'b0, 2'b00, 32'hFFFFFFFD, 32'd5);
    wait_done(1'b0, 1'b0, lat, bc);
    check("mult_hi", {32'd0, hi32}, 64'hFFFFFFFF);
    check("mult_lo", {32'd0, lo32}, 64'hFFFFFFF1);
    issue(1'b0, 2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done(1'b0, 1'b0, lat, bc);
    check("div_lo", {32'd0, lo32}, 64'hFFFFFFFD);
    check("div_hi", {32'd0, hi32}, 64'hFFFFFFFF);
    check("b2b_lat", 64'(lat), 64'd33);

    issue(1'b0, 2'b11, 32'd100, 32'd0);
    wait_done(1'b0, 1'b0, lat, bc);
    check("divu0_lo", {32'd0, lo32}, 64'hFFFFFFFF);
    check("divu0_hi", {32'd0, hi32}, 64'h00000064);
    check("divu0_lat", 64'(lat), 64'd33);
    issue(1'b0, 2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done(1'b0, 1'b0, lat, bc);
    check("divmn_lo", {32'd0, lo32}, 64'h80000000);
    check("divmn_hi", {32'd0, hi32}, 64'h00000000);

    // Start and HiWrite during an operation are ignored
    ref_model(32, 2'b01, 32'd1234, 32'd5678, eh, el);
    issue(1'b0, 2'b01, 32'd1234, 32'd5678);
    wait_done(1'b0, 1'b1, lat, bc);
    check("busyign_hi", {32'd0, hi32}, {32'd0, eh});
    check("busyign_lo", {32'd0, lo32}, {32'd0, el});
    repeat (3) @(negedge clk);
    check("noqueue_busy", {63'd0, busy32}, 64'd0);

    // MTLO / MTHI in IDLE
    lw32 = 1'b1; wd32 = 32'h12345678;
    @(negedge clk);
    lw32 = 1'b0;
    check("mtlo_lo", {32'd0, lo32}, 64'h12345678);
    check("mtlo_hi", {32'd0, hi32}, {32'd0, eh});
    hw32 = 1'b1; wd32 = 32'hCAFEF00D;
    @(negedge clk);
    hw32 = 1'b0;
    check("mthi_hi", {32'd0, hi32}, 64'hCAFEF00D);
    check("mthi_lo", {32'd0, lo32}, 64'h12345678);

    // Start together with LoWrite: write lands, result overwrites
    lw32 = 1'b1; wd32 = 32'h55AA55AA;
    issue(1'b0, 2'b11, 32'd1000, 32'd7);
    lw32 = 1'b0;
    check("startwr_lo", {32'd0, lo32}, 64'h55AA55AA);
    wait_done(1'b0, 1'b0, lat, bc);
    check("startwr_q", {32'd0, lo32}, 64'd142);
    check("startwr_r", {32'd0, hi32}, 64'd6);

    // Asynchronous reset mid-operation
    issue(1'b0, 2'b01, 32'hFFFF, 32'hFFFF);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {63'd0, busy32}, 64'd0);
    check("abort_hi", {32'd0, hi32}, 64'd0);
    check("abort_lo", {32'd0, lo32}, 64'd0);
    dcount = 0;
    repeat (3) begin @(negedge clk); if (done32 !== 1'b0) dcount++; end
    rst = 1'b0;
    repeat (40) begin @(negedge clk); if (done32 !== 1'b0 || busy32 !== 1'b0) dcount++; end
    check("abort_nodone", 64'(dcount), 64'd0);
    issue(1'b0, 2'b01, 32'd7, 32'd6);
    wait_done(1'b0, 1'b0, lat, bc);
    check("post_lo", {32'd0, lo32}, 64'd42);
    check("post_hi", {32'd0, hi32}, 64'd0);

    // WIDTH = 8 instance
    issue(1'b1, 2'b00, 32'h80, 32'h80);
    wait_done(1'b1, 1'b0, lat, bc);
    check("w8_hi", {56'd0, hi8}, 64'h40);
    check("w8_lo", {56'd0, lo8}, 64'h00);
    check("w8_lat", 64'(lat), 64'd9);
    check("w8_busy", 64'(bc), 64'd9);
    run_check(1'b1, "w8_divmn", 2'b10, 32'h80, 32'hFF);

    for (int i = 0; i < 1000; i++) begin
      logic [1:0] rop = 2'($urandom);
      logic [31:0] ra = $urandom;
      logic [31:0] rb = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
      run_check(1'b1, "rnd8", rop, ra, rb);
      if (n_fail > 20) break;
    end
    for (int i = 0; i < 200; i++) begin
      logic [1:0] rop = 2'($urandom);
      logic [31:0] ra = $urandom;
      logic [31:0] rb = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
      run_check(1'b0, "rnd32", rop, ra, rb);
      if (n_fail > 20) break;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
